// File: rtl/fe_atr_sequencer.sv
// fe_atr_sequencer: per-channel TX/RX front-end switch and PA sequencer.
// Guards PA turn-on with a settle delay and switch release with a hold delay.
module fe_atr_sequencer #(
  parameter int NUM_CH    = 2,
  parameter int SW_WIDTH  = 4,
  parameter int DLY_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            tx_active,
  input  logic [NUM_CH-1:0]            rx_active,
  input  logic [NUM_CH*SW_WIDTH-1:0]   cfg_idle,
  input  logic [NUM_CH*SW_WIDTH-1:0]   cfg_rx,
  input  logic [NUM_CH*SW_WIDTH-1:0]   cfg_tx,
  input  logic [NUM_CH*SW_WIDTH-1:0]   cfg_fdx,
  input  logic [DLY_WIDTH-1:0]         tx_on_dly,
  input  logic [DLY_WIDTH-1:0]         tx_off_dly,
  output logic [NUM_CH*SW_WIDTH-1:0]   sw_out,
  output logic [NUM_CH-1:0]            pa_en,
  output logic [NUM_CH-1:0]            tx_led,
  output logic [NUM_CH-1:0]            rx_led,
  output logic [NUM_CH*3-1:0]          state_rb
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RX     = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_ON     = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [DLY_WIDTH-1:0] CNT_ONE = 1;

  logic [2:0]           state_q [NUM_CH];
  logic [2:0]           state_d [NUM_CH];
  logic [DLY_WIDTH-1:0] cnt_q   [NUM_CH];
  logic [DLY_WIDTH-1:0] cnt_d   [NUM_CH];

  logic [NUM_CH*SW_WIDTH-1:0] sw_d;
  logic [NUM_CH-1:0]          pa_d;
  logic [NUM_CH-1:0]          txl_d;

  // Next-state and delay counter for every channel
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!ch_enable[i]) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          S_IDLE, S_RX: begin
            if (tx_active[i]) begin
              state_d[i] = S_SETTLE;
              cnt_d[i]   = tx_on_dly;
            end else if (rx_active[i]) begin
              state_d[i] = S_RX;
            end else begin
              state_d[i] = S_IDLE;
            end
          end
          S_SETTLE: begin
            if (!tx_active[i])
              state_d[i] = rx_active[i] ? S_RX : S_IDLE;
            else if (cnt_q[i] == '0)
              state_d[i] = S_ON;
            else
              cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
          S_ON: begin
            if (!tx_active[i]) begin
              state_d[i] = S_HOLD;
              cnt_d[i]   = tx_off_dly;
            end
          end
          S_HOLD: begin
            if (tx_active[i])
              state_d[i] = S_ON;
            else if (cnt_q[i] == '0)
              state_d[i] = rx_active[i] ? S_RX : S_IDLE;
            else
              cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
          default: begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Output decode from the current state, registered below
  always_comb begin
    sw_d  = '0;
    pa_d  = '0;
    txl_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (state_q[i])
        S_RX:
          sw_d[i*SW_WIDTH +: SW_WIDTH] = cfg_rx[i*SW_WIDTH +: SW_WIDTH];
        S_SETTLE, S_ON, S_HOLD: begin
          sw_d[i*SW_WIDTH +: SW_WIDTH] = rx_active[i]
            ? cfg_fdx[i*SW_WIDTH +: SW_WIDTH]
            : cfg_tx[i*SW_WIDTH +: SW_WIDTH];
          txl_d[i] = 1'b1;
        end
        default:
          sw_d[i*SW_WIDTH +: SW_WIDTH] = cfg_idle[i*SW_WIDTH +: SW_WIDTH];
      endcase
      pa_d[i] = (state_q[i] == S_ON);
    end
  end

  // Readback exposes the live state register
  always_comb begin
    state_rb = '0;
    for (int i = 0; i < NUM_CH; i++)
      state_rb[i*3 +: 3] = state_q[i];
  end

  // State, counters and pin registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      sw_out <= '0;
      pa_en  <= '0;
      tx_led <= '0;
      rx_led <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sw_out <= sw_d;
      pa_en  <= pa_d;
      tx_led <= txl_d;
      rx_led <= rx_active & ch_enable;
    end
  end

endmodule

// File: tb/tb_fe_atr_sequencer.sv
// tb_fe_atr_sequencer: directed vectors for the ATR sequencer.
// Second instance covers a 4-channel, 6-bit switch build.
module tb_fe_atr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ch_enable, tx_active, rx_active;
  logic [7:0]  cfg_idle, cfg_rx, cfg_tx, cfg_fdx;
  logic [15:0] tx_on_dly, tx_off_dly;
  logic [7:0]  sw_out;
  logic [1:0]  pa_en, tx_led, rx_led;
  logic [5:0]  state_rb;

  logic [3:0]  b_en, b_tx, b_rx;
  logic [23:0] b_idle, b_crx, b_ctx, b_fdx, b_sw;
  logic [3:0]  b_pa, b_txl, b_rxl;
  logic [11:0] b_st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fe_atr_sequencer #(.NUM_CH(2), .SW_WIDTH(4), .DLY_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable),
    .tx_active(tx_active), .rx_active(rx_active),
    .cfg_idle(cfg_idle), .cfg_rx(cfg_rx), .cfg_tx(cfg_tx),
    .cfg_fdx(cfg_fdx), .tx_on_dly(tx_on_dly),
    .tx_off_dly(tx_off_dly), .sw_out(sw_out), .pa_en(pa_en),
    .tx_led(tx_led), .rx_led(rx_led), .state_rb(state_rb)
  );

  fe_atr_sequencer #(.NUM_CH(4), .SW_WIDTH(6), .DLY_WIDTH(16)) dut4 (
    .clk(clk), .reset_n(reset_n), .ch_enable(b_en),
    .tx_active(b_tx), .rx_active(b_rx),
    .cfg_idle(b_idle), .cfg_rx(b_crx), .cfg_tx(b_ctx),
    .cfg_fdx(b_fdx), .tx_on_dly(tx_on_dly),
    .tx_off_dly(tx_off_dly), .sw_out(b_sw), .pa_en(b_pa),
    .tx_led(b_txl), .rx_led(b_rxl), .state_rb(b_st)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    ch_enable  = 2'b11;
    tx_active  = 2'b00;
    rx_active  = 2'b00;
    cfg_idle   = 8'h15;
    cfg_rx     = 8'h23;
    cfg_tx     = 8'h4A;
    cfg_fdx    = 8'h8C;
    tx_on_dly  = 16'd3;
    tx_off_dly = 16'd2;
    b_en   = 4'hF;
    b_tx   = 4'h0;
    b_rx   = 4'h0;
    b_idle = {6'h15, 18'h0};
    b_crx  = {6'h07, 18'h0};
    b_ctx  = {6'h2A, 18'h0};
    b_fdx  = {6'h38, 18'h0};

    // reset: edges 1..3
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_sw", 32'(sw_out), 32'h0);
      check("rst_pa", 32'(pa_en), 32'h0);
      check("rst_st", 32'(state_rb), 32'h0);
      check("rst_led", 32'({tx_led, rx_led}), 32'h0);
    end
    reset_n = 1'b1;
    tick(); // edge 4
    check("rel_sw", 32'(sw_out), 32'h15);
    check("rel_st", 32'(state_rb), 32'h0);
    check("rel_b_sw", 32'(b_sw), 32'(b_idle));

    // settle sequencing, tx sampled at edge 10
    for (int i = 0; i < 5; i++) tick();
    tx_active[0] = 1'b1;
    b_tx[3]      = 1'b1;
    tick(); // 10
    check("s2_st10", 32'(state_rb[2:0]), 32'd2);
    check("s2_sw10", 32'(sw_out[3:0]), 32'h5);
    check("s2_led10", 32'(tx_led[0]), 32'd0);
    check("b_st10", 32'(b_st[11:9]), 32'd2);
    tick(); // 11
    check("s2_sw11", 32'(sw_out[3:0]), 32'hA);
    check("s2_led11", 32'(tx_led[0]), 32'd1);
    check("b_sw11", 32'(b_sw[23:18]), 32'h2A);
    for (int e = 12; e <= 14; e++) begin
      tick();
      check("s2_pa_early", 32'(pa_en[0]), 32'd0);
      check("b_pa_early", 32'(b_pa[3]), 32'd0);
    end
    check("s2_st14", 32'(state_rb[2:0]), 32'd3);
    tick(); // 15
    check("s2_pa15", 32'(pa_en[0]), 32'd1);
    check("b_pa15", 32'(b_pa), 32'h8);
    check("s2_pa1", 32'(pa_en[1]), 32'd0);

    // hold sequencing with rx active
    rx_active[0] = 1'b1;
    tick(); // 16
    check("s3_fdx16", 32'(sw_out[3:0]), 32'hC);
    tx_active[0] = 1'b0;
    tick(); // 17
    check("s3_st17", 32'(state_rb[2:0]), 32'd4);
    check("s3_pa17", 32'(pa_en[0]), 32'd1);
    tick(); // 18
    check("s3_pa18", 32'(pa_en[0]), 32'd0);
    check("s3_sw18", 32'(sw_out[3:0]), 32'hC);
    check("s3_st18", 32'(state_rb[2:0]), 32'd4);
    tick(); // 19
    check("s3_sw19", 32'(sw_out[3:0]), 32'hC);
    check("s3_st19", 32'(state_rb[2:0]), 32'd4);
    tick(); // 20
    check("s3_sw20", 32'(sw_out[3:0]), 32'hC);
    check("s3_st20", 32'(state_rb[2:0]), 32'd1);
    tick(); // 21
    check("s3_sw21", 32'(sw_out[3:0]), 32'h3);
    check("s3_rxl", 32'(rx_led[0]), 32'd1);

    // abort during settle
    rx_active[0] = 1'b0;
    tick(); // 22
    check("s4_st22", 32'(state_rb[2:0]), 32'd0);
    tick(); // 23
    check("s4_sw23", 32'(sw_out[3:0]), 32'h5);
    tx_active[0] = 1'b1;
    for (int e = 24; e <= 26; e++) begin
      tick();
      check("s4_pa", 32'(pa_en[0]), 32'd0);
    end
    check("s4_st26", 32'(state_rb[2:0]), 32'd2);
    check("s4_sw26", 32'(sw_out[3:0]), 32'hA);
    tx_active[0] = 1'b0;
    tick(); // 27
    check("s4_st27", 32'(state_rb[2:0]), 32'd0);
    check("s4_pa27", 32'(pa_en[0]), 32'd0);
    tick(); // 28
    check("s4_sw28", 32'(sw_out[3:0]), 32'h5);
    check("s4_pa28", 32'(pa_en[0]), 32'd0);

    // re-key during hold
    tx_active[0] = 1'b1;
    for (int e = 29; e <= 33; e++) tick();
    check("s5_st33", 32'(state_rb[2:0]), 32'd3);
    tick(); // 34
    check("s5_pa34", 32'(pa_en[0]), 32'd1);
    tx_active[0] = 1'b0;
    tick(); // 35
    check("s5_st35", 32'(state_rb[2:0]), 32'd4);
    tick(); // 36
    check("s5_pa36", 32'(pa_en[0]), 32'd0);
    tx_active[0] = 1'b1;
    tick(); // 37
    check("s5_st37", 32'(state_rb[2:0]), 32'd3);
    check("s5_pa37", 32'(pa_en[0]), 32'd0);
    tick(); // 38
    check("s5_pa38", 32'(pa_en[0]), 32'd1);

    // channel disable, ch0 in RX and ch1 in TX_ON
    tx_active = 2'b10;
    rx_active = 2'b01;
    for (int e = 39; e <= 46; e++) tick();
    check("s6_st46", 32'(state_rb), 32'o31);
    check("s6_pa46", 32'(pa_en), 32'h2);
    ch_enable[1] = 1'b0;
    tick(); // 47
    check("s6_st47", 32'(state_rb), 32'o01);
    check("s6_pa47", 32'(pa_en), 32'h2);
    check("s6_txl47", 32'(tx_led), 32'h2);
    tick(); // 48
    check("s6_pa48", 32'(pa_en), 32'h0);
    check("s6_sw48", 32'(sw_out), 32'h13);
    check("s6_led48", 32'({tx_led, rx_led}), 32'h1);
    check("s6_st48", 32'(state_rb), 32'o01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
